// File: rtl/mpu_multimode.sv
// Message processing unit: buffers vertex updates, read-modify-writes the HBM word with a
// run-time selected reduction (MIN / MAX / thresholded ADD) and forwards activated vertices to the MGU.
module mpu_multimode #(
  parameter int VPropWidth   = 32,
  parameter int VPropStart   = 64,
  parameter int EIndexWidth  = 32,
  parameter int EDegreeWidth = 32,
  parameter int AddrWidth    = 33,
  parameter int DataWidth    = 256,
  parameter int UpdateWidth  = 65,
  parameter int FifoDepth    = 4
) (
  input  logic                                        clk,
  input  logic                                        resetn,
  input  logic [UpdateWidth-1:0]                      upd_data,
  input  logic                                        upd_valid,
  output logic                                        upd_ready,
  input  logic [1:0]                                  mode,
  input  logic [VPropWidth-1:0]                       threshold,
  output logic [AddrWidth-1:0]                        rd_addr,
  output logic                                        rd_start,
  input  logic [DataWidth-1:0]                        rd_data,
  input  logic                                        rd_done,
  output logic [AddrWidth-1:0]                        wr_addr,
  output logic [DataWidth-1:0]                        wr_data,
  output logic                                        wr_start,
  input  logic                                        wr_done,
  output logic [VPropWidth+EIndexWidth+EDegreeWidth-1:0] mgu_data,
  output logic                                        mgu_valid,
  input  logic                                        mgu_ready,
  output logic [31:0]                                 active_count,
  output logic                                        busy
);
  localparam int MguWidth = VPropWidth + EIndexWidth + EDegreeWidth;
  localparam int PtrW     = $clog2(FifoDepth);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_READ_WAIT, S_REDUCE, S_WRITE, S_WRITE_WAIT, S_SEND
  } state_e;

  state_e                  state_q, state_d;
  logic [PtrW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [UpdateWidth-1:0]  fifo_mem_q [FifoDepth];
  logic [UpdateWidth-1:0]  fifo_mem_d [FifoDepth];
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [VPropWidth-1:0]   val_q, val_d, thr_q, thr_d;
  logic [1:0]              mode_q, mode_d;
  logic [DataWidth-1:0]    word_q, word_d, wr_data_q, wr_data_d;
  logic [MguWidth-1:0]     mgu_data_q, mgu_data_d;
  logic                    active_q, active_d;
  logic [31:0]             active_count_q, active_count_d;

  logic                    fifo_empty, fifo_full, push;
  logic [UpdateWidth-1:0]  head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign push       = upd_valid && !fifo_full;
  assign head       = fifo_mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wptr_q[PtrW-1:0]] = upd_data;
  end

  // Reduction datapath, evaluated from the captured word in REDUCE.
  logic [VPropWidth-1:0]   red_n, red_p, red_t, red_sum, red_gain, red_new_p, red_new_t;
  logic [EDegreeWidth-1:0] red_deg;
  logic [EIndexWidth-1:0]  red_idx;
  logic                    red_act, red_wr;
  logic [DataWidth-1:0]    red_word;

  always_comb begin
    red_n     = val_q;
    red_p     = word_q[VPropStart +: VPropWidth];
    red_t     = word_q[VPropStart+VPropWidth +: VPropWidth];
    red_deg   = word_q[EDegreeWidth-1:0];
    red_idx   = word_q[EDegreeWidth +: EIndexWidth];
    red_sum   = red_t + red_n;
    red_gain  = red_sum - red_p;
    red_new_p = red_p;
    red_new_t = red_t;
    red_act   = 1'b0;
    red_wr    = 1'b0;
    case (mode_q)
      2'b01: begin
        red_new_t = red_sum;
        red_act   = (red_gain >= thr_q) && (red_deg != '0);
        red_new_p = red_act ? red_sum : red_p;
        red_wr    = 1'b1;
      end
      2'b10: begin
        red_act = (red_n < red_t) && (red_deg != '0);
        red_wr  = red_act;
      end
      2'b11: begin
        red_act = (red_n > red_t) && (red_deg != '0);
        red_wr  = red_act;
      end
      default: ;
    endcase
    if (mode_q[1] && red_act) begin
      red_new_p = red_n;
      red_new_t = red_n;
    end
    red_word = word_q;
    red_word[VPropStart +: VPropWidth]            = red_new_p;
    red_word[VPropStart+VPropWidth +: VPropWidth] = red_new_t;
  end

  always_comb begin
    state_d        = state_q;
    wptr_d         = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d         = rptr_q;
    addr_d         = addr_q;
    val_d          = val_q;
    mode_d         = mode_q;
    thr_d          = thr_q;
    word_d         = word_q;
    wr_data_d      = wr_data_q;
    mgu_data_d     = mgu_data_q;
    active_d       = active_q;
    active_count_d = active_count_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          rptr_d = rptr_q + 1'b1;
          // Drop-mode messages are consumed here with no memory traffic.
          if (mode != 2'b00) begin
            addr_d  = head[UpdateWidth-1 -: AddrWidth];
            val_d   = head[VPropWidth-1:0];
            mode_d  = mode;
            thr_d   = threshold;
            state_d = S_READ;
          end
        end
      end
      S_READ:      state_d = S_READ_WAIT;
      S_READ_WAIT: begin
        if (rd_done) begin
          word_d  = rd_data;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        wr_data_d  = red_word;
        mgu_data_d = {red_new_p, red_idx, red_deg};
        active_d   = red_act;
        state_d    = red_wr ? S_WRITE : S_IDLE;
      end
      S_WRITE:      state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        if (wr_done) state_d = active_q ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        if (mgu_ready) begin
          active_count_d = active_count_q + 32'd1;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) fifo_mem_q <= fifo_mem_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      wptr_q         <= '0;
      rptr_q         <= '0;
      addr_q         <= '0;
      val_q          <= '0;
      mode_q         <= '0;
      thr_q          <= '0;
      word_q         <= '0;
      wr_data_q      <= '0;
      mgu_data_q     <= '0;
      active_q       <= 1'b0;
      active_count_q <= '0;
    end else begin
      state_q        <= state_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      addr_q         <= addr_d;
      val_q          <= val_d;
      mode_q         <= mode_d;
      thr_q          <= thr_d;
      word_q         <= word_d;
      wr_data_q      <= wr_data_d;
      mgu_data_q     <= mgu_data_d;
      active_q       <= active_d;
      active_count_q <= active_count_d;
    end
  end

  assign upd_ready    = !fifo_full;
  assign rd_start     = (state_q == S_READ);
  assign wr_start     = (state_q == S_WRITE);
  assign mgu_valid    = (state_q == S_SEND);
  assign rd_addr      = addr_q;
  assign wr_addr      = addr_q;
  assign wr_data      = wr_data_q;
  assign mgu_data     = mgu_data_q;
  assign active_count = active_count_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_mpu_multimode.sv
// Bench for mpu_multimode: behavioural HBM/MGU models, a message-level reference model and
// per-scenario tasks covering reset, reductions, wrap, backpressure, random traffic and mid-op reset.
module tb_mpu_multimode;
  localparam int VW = 32, VS = 64, AW = 33, DW = 256, UW = 65;

  logic          clk = 1'b0;
  logic          resetn;
  logic [UW-1:0] upd_data;
  logic          upd_valid, upd_ready;
  logic [1:0]    mode;
  logic [VW-1:0] threshold;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_start, rd_done, wr_start, wr_done;
  logic [DW-1:0] rd_data, wr_data;
  logic [95:0]   mgu_data;
  logic          mgu_valid, mgu_ready;
  logic [31:0]   active_count;
  logic          busy;

  mpu_multimode dut (
    .clk(clk), .resetn(resetn), .upd_data(upd_data), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .mode(mode), .threshold(threshold), .rd_addr(rd_addr), .rd_start(rd_start), .rd_data(rd_data),
    .rd_done(rd_done), .wr_addr(wr_addr), .wr_data(wr_data), .wr_start(wr_start), .wr_done(wr_done),
    .mgu_data(mgu_data), .mgu_valid(mgu_valid), .mgu_ready(mgu_ready), .active_count(active_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_total = 0;
  int rd_lat = 1, wr_lat = 1;
  int exp_cnt = 0;

  logic [DW-1:0] mem  [logic [AW-1:0]];
  logic [DW-1:0] mmem [logic [AW-1:0]];

  logic [AW-1:0]    obs_rd[$], exp_rd[$];
  logic [AW+DW-1:0] obs_wr[$], exp_wr[$];
  logic [95:0]      obs_mgu[$], exp_mgu[$];

  // HBM read port model
  initial begin : rd_resp
    logic [AW-1:0] a;
    rd_done = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      if (rd_start === 1'b1) begin
        a = rd_addr;
        obs_rd.push_back(a);
        repeat (rd_lat) @(posedge clk);
        #1;
        rd_data = mem.exists(a) ? mem[a] : '0;
        rd_done = 1'b1;
        @(posedge clk);
        #1 rd_done = 1'b0;
      end
    end
  end

  // HBM write port model
  initial begin : wr_resp
    logic [AW-1:0] a;
    wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_start === 1'b1) begin
        a = wr_addr;
        obs_wr.push_back({a, wr_data});
        mem[a] = wr_data;
        repeat (wr_lat) @(posedge clk);
        #1 wr_done = 1'b1;
        @(posedge clk);
        #1 wr_done = 1'b0;
      end
    end
  end

  always @(negedge clk)
    if (mgu_valid === 1'b1 && mgu_ready === 1'b1 && resetn === 1'b1) obs_mgu.push_back(mgu_data);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic init_word(input logic [AW-1:0] a, input logic [31:0] temp, input logic [31:0] prop,
                           input logic [31:0] idx, input logic [31:0] deg);
    logic [DW-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, temp, prop, idx, deg};
    mem[a]  = w;
    mmem[a] = w;
  endtask

  // Message-level model: applies one update to the model memory using the current mode/threshold.
  task automatic model_msg(input logic [AW-1:0] a, input logic [31:0] n);
    logic [DW-1:0] w;
    logic [31:0] p, t, d, idx;
    longint sum, gain;
    bit act, wr;
    w   = mmem.exists(a) ? mmem[a] : '0;
    p   = w[VS +: 32];
    t   = w[VS+32 +: 32];
    idx = w[63:32];
    d   = w[31:0];
    act = 1'b0;
    wr  = 1'b0;
    if (mode == 2'd0) return;
    exp_rd.push_back(a);
    if (mode == 2'd1) begin
      sum  = (longint'(t) + longint'(n)) % 64'sh1_0000_0000;
      gain = (sum - longint'(p) + 64'sh1_0000_0000) % 64'sh1_0000_0000;
      act  = (gain >= longint'(threshold)) && (d != 0);
      t    = 32'(sum);
      if (act) p = t;
      wr = 1'b1;
    end else begin
      act = ((mode == 2'd2) ? (n < t) : (n > t)) && (d != 0);
      if (act) begin p = n; t = n; end
      wr = act;
    end
    if (wr) begin
      w[VS +: 32]    = p;
      w[VS+32 +: 32] = t;
      mmem[a] = w;
      exp_wr.push_back({a, w});
    end
    if (act) begin
      exp_mgu.push_back({p, idx, d});
      exp_cnt++;
    end
  endtask

  // Call at a negedge; returns at the negedge after acceptance with upd_valid still high.
  task automatic push(input logic [AW-1:0] a, input logic [31:0] n);
    int g;
    g = 0;
    upd_data  = {a, n};
    upd_valid = 1'b1;
    while (upd_ready !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (upd_ready === 1'b1) model_msg(a, n);
    else begin
      n_total++;
      $display("FAIL push_timeout: upd_ready=%b required 1", upd_ready);
    end
    @(negedge clk);
  endtask

  task automatic drain(input bit rnd);
    int g;
    bit done;
    g = 0;
    done = 1'b0;
    while (!done && g < 3000) begin
      @(posedge clk);
      #1;
      if (rnd) mgu_ready = 1'($urandom_range(0, 1));
      if (busy === 1'b0) done = 1'b1;
      g++;
    end
    mgu_ready = 1'b1;
    if (!done) begin
      n_total++;
      $display("FAIL drain_timeout: busy=%b required 0", busy);
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic sb_check(input string tag);
    n_total++;
    if (obs_rd.size() != exp_rd.size())
      $display("FAIL %s read_count: got %0d want %0d", tag, obs_rd.size(), exp_rd.size());
    else n_pass++;
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++) begin
      n_total++;
      if (obs_rd[i] !== exp_rd[i]) $display("FAIL %s rd_addr[%0d]: got %h want %h", tag, i, obs_rd[i], exp_rd[i]);
      else n_pass++;
    end
    n_total++;
    if (obs_wr.size() != exp_wr.size())
      $display("FAIL %s write_count: got %0d want %0d", tag, obs_wr.size(), exp_wr.size());
    else n_pass++;
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      n_total++;
      if (obs_wr[i] !== exp_wr[i]) $display("FAIL %s write[%0d]: got %h want %h", tag, i, obs_wr[i], exp_wr[i]);
      else n_pass++;
    end
    n_total++;
    if (obs_mgu.size() != exp_mgu.size())
      $display("FAIL %s mgu_count: got %0d want %0d", tag, obs_mgu.size(), exp_mgu.size());
    else n_pass++;
    for (int i = 0; i < obs_mgu.size() && i < exp_mgu.size(); i++) begin
      n_total++;
      if (obs_mgu[i] !== exp_mgu[i]) $display("FAIL %s mgu[%0d]: got %h want %h", tag, i, obs_mgu[i], exp_mgu[i]);
      else n_pass++;
    end
    n_total++;
    if (active_count !== 32'(exp_cnt)) $display("FAIL %s active_count: got %0d want %0d", tag, active_count, exp_cnt);
    else n_pass++;
    obs_rd.delete(); exp_rd.delete(); obs_wr.delete(); exp_wr.delete(); obs_mgu.delete(); exp_mgu.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({upd_ready, rd_start, wr_start, mgu_valid, busy} !== 5'b10000)
      $display("FAIL reset_ctrl: {upd_ready,rd_start,wr_start,mgu_valid,busy}=%b required 10000",
               {upd_ready, rd_start, wr_start, mgu_valid, busy});
    else n_pass++;
    n_total++;
    if ({rd_addr, wr_addr} !== '0) $display("FAIL reset_addr: rd=%h wr=%h required 0", rd_addr, wr_addr);
    else n_pass++;
    n_total++;
    if ({wr_data, mgu_data} !== '0) $display("FAIL reset_data: wr_data=%h mgu_data=%h required 0", wr_data, mgu_data);
    else n_pass++;
    n_total++;
    if (active_count !== 32'd0) $display("FAIL reset_count: active_count=%0d required 0", active_count);
    else n_pass++;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_min();
    int t0, l_rd, l_wr, l_mgu;
    logic [AW+DW-1:0] w;
    l_rd = -1; l_wr = -1; l_mgu = -1;
    init_word(33'h100, 32'd10, 32'd10, 32'h100, 32'd3);
    mode = 2'd2; threshold = '0; mgu_ready = 1'b1;
    @(negedge clk);
    push(33'h100, 32'd4);
    upd_valid = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_start === 1'b1 && l_rd < 0) l_rd = cyc - t0;
      if (wr_start === 1'b1 && l_wr < 0) l_wr = cyc - t0;
      if (mgu_valid === 1'b1 && l_mgu < 0) l_mgu = cyc - t0;
    end
    drain(1'b0);
    n_total++;
    if ({l_rd, l_wr, l_mgu} !== {32'd1, 32'd4, 32'd6})
      $display("FAIL min_latency: rd=%0d wr=%0d mgu=%0d required 1 4 6", l_rd, l_wr, l_mgu);
    else n_pass++;
    w = (obs_wr.size() > 0) ? obs_wr[0] : 'x;
    n_total++;
    if (w[VS+32 +: 32] !== 32'd4 || w[VS +: 32] !== 32'd4)
      $display("FAIL min_write: temp=%0d prop=%0d required 4 4", w[VS+32 +: 32], w[VS +: 32]);
    else n_pass++;
    n_total++;
    if (obs_mgu.size() != 1 || obs_mgu[0] !== {32'd4, 32'h100, 32'd3})
      $display("FAIL min_mgu: count=%0d data=%h required 1 {4,100,3}", obs_mgu.size(),
               (obs_mgu.size() > 0) ? obs_mgu[0] : 96'h0);
    else n_pass++;
    n_total++;
    if (active_count !== 32'd1) $display("FAIL min_count: active_count=%0d required 1", active_count);
    else n_pass++;
    sb_check("min");
  endtask

  task automatic test_no_activate();
    init_word(33'h200, 32'd10, 32'd10, 32'h100, 32'd3);
    init_word(33'h220, 32'd10, 32'd10, 32'h200, 32'd0);
    mode = 2'd2;
    @(negedge clk);
    push(33'h200, 32'd12);
    push(33'h220, 32'd4);
    upd_valid = 1'b0;
    drain(1'b0);
    n_total++;
    if (obs_wr.size() != 0 || obs_mgu.size() != 0 || obs_rd.size() != 2)
      $display("FAIL noact_traffic: writes=%0d mgu=%0d reads=%0d required 0 0 2",
               obs_wr.size(), obs_mgu.size(), obs_rd.size());
    else n_pass++;
    mode = 2'd0;
    @(negedge clk);
    push(33'h200, 32'd1);
    push(33'h220, 32'd1);
    upd_valid = 1'b0;
    drain(1'b0);
    n_total++;
    if (obs_rd.size() != 2 || busy !== 1'b0)
      $display("FAIL drop_mode: reads=%0d busy=%b required 2 0", obs_rd.size(), busy);
    else n_pass++;
    sb_check("noact");
  endtask

  task automatic test_add();
    logic [AW+DW-1:0] w;
    init_word(33'h300, 32'd10, 32'd10, 32'h300, 32'd2);
    mode = 2'd1; threshold = 32'd5;
    @(negedge clk);
    push(33'h300, 32'd3);
    upd_valid = 1'b0;
    drain(1'b0);
    w = (obs_wr.size() > 0) ? obs_wr[0] : 'x;
    n_total++;
    if (w[VS+32 +: 32] !== 32'd13 || w[VS +: 32] !== 32'd10 || obs_mgu.size() != 0)
      $display("FAIL add_below: temp=%0d prop=%0d mgu=%0d required 13 10 0", w[VS+32 +: 32], w[VS +: 32], obs_mgu.size());
    else n_pass++;
    sb_check("add1");
    @(negedge clk);
    push(33'h300, 32'd3);
    upd_valid = 1'b0;
    drain(1'b0);
    w = (obs_wr.size() > 0) ? obs_wr[0] : 'x;
    n_total++;
    if (w[VS+32 +: 32] !== 32'd16 || w[VS +: 32] !== 32'd16 || obs_mgu.size() != 1 || obs_mgu[0][95:64] !== 32'd16)
      $display("FAIL add_above: temp=%0d prop=%0d mgu=%0d required 16 16 1", w[VS+32 +: 32], w[VS +: 32], obs_mgu.size());
    else n_pass++;
    sb_check("add2");
  endtask

  task automatic test_wrap();
    logic [AW+DW-1:0] w;
    init_word(33'h400, 32'd7, 32'd7, 32'h400, 32'd1);
    init_word(33'h420, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h420, 32'd1);
    mode = 2'd3;
    @(negedge clk);
    push(33'h400, 32'hFFFF_FFFF);
    upd_valid = 1'b0;
    drain(1'b0);
    n_total++;
    if (obs_mgu.size() != 1 || obs_mgu[0][95:64] !== 32'hFFFF_FFFF)
      $display("FAIL max_extreme: mgu=%0d required 1 with prop ffffffff", obs_mgu.size());
    else n_pass++;
    sb_check("max");
    // gain after wrap is exactly the threshold, so this must activate
    mode = 2'd1; threshold = 32'd4;
    @(negedge clk);
    push(33'h420, 32'd3);
    upd_valid = 1'b0;
    drain(1'b0);
    w = (obs_wr.size() > 0) ? obs_wr[0] : 'x;
    n_total++;
    if (w[VS+32 +: 32] !== 32'd1 || w[VS +: 32] !== 32'd1)
      $display("FAIL add_wrap: temp=%0d prop=%0d required 1 1", w[VS+32 +: 32], w[VS +: 32]);
    else n_pass++;
    sb_check("wrap");
  endtask

  task automatic test_back_to_back();
    mode = 2'd3; threshold = '0;
    for (int i = 0; i < 6; i++) init_word(33'h1000 + 33'(i * 32), 32'd0, 32'd0, 32'(i), 32'd1);
    @(posedge clk);
    #1 mgu_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(33'h1000 + 33'(i * 32), 32'(i + 1));
    n_total++;
    if (upd_ready !== 1'b0 || busy !== 1'b1) $display("FAIL bp_full: upd_ready=%b busy=%b required 0 1", upd_ready, busy);
    else n_pass++;
    fork
      push(33'h10A0, 32'd6);
      begin
        repeat (6) @(negedge clk);
        n_total++;
        if (upd_ready !== 1'b0 || mgu_valid !== 1'b1)
          $display("FAIL bp_stall: upd_ready=%b mgu_valid=%b required 0 1", upd_ready, mgu_valid);
        else n_pass++;
        @(posedge clk);
        #1 mgu_ready = 1'b1;
      end
    join
    upd_valid = 1'b0;
    drain(1'b0);
    sb_check("backpressure");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      init_word(33'h2000 + 33'(i * 32), $urandom_range(0, 100), $urandom_range(0, 100), $urandom,
                ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 9)));
    for (int b = 0; b < 8; b++) begin
      mode = 2'($urandom_range(0, 3));
      threshold = $urandom_range(0, 40);
      rd_lat = $urandom_range(1, 3);
      wr_lat = $urandom_range(1, 3);
      @(negedge clk);
      for (int m = 0; m < 8; m++) begin
        push(33'h2000 + 33'($urandom_range(0, 3) * 32),
             ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 120)));
        if ($urandom_range(0, 2) == 0) begin
          upd_valid = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
      end
      upd_valid = 1'b0;
      drain(1'b1);
      sb_check("random");
    end
    rd_lat = 1;
    wr_lat = 1;
  endtask

  task automatic test_reset_mid();
    int g, starts;
    init_word(33'h3000, 32'd50, 32'd50, 32'd7, 32'd1);
    init_word(33'h3020, 32'd50, 32'd50, 32'd8, 32'd1);
    mode = 2'd2; wr_lat = 6;
    @(negedge clk);
    push(33'h3000, 32'd3);
    push(33'h3020, 32'd4);
    upd_valid = 1'b0;
    g = 0;
    while (wr_start !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_total++;
    if (wr_start !== 1'b1) $display("FAIL rst_mid_reach: wr_start=%b required 1", wr_start);
    else n_pass++;
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({upd_ready, rd_start, wr_start, mgu_valid, busy} !== 5'b10000 || active_count !== 32'd0 ||
        {rd_addr, wr_addr, wr_data, mgu_data} !== '0)
      $display("FAIL rst_mid_state: ctrl=%b count=%0d rd_addr=%h required 10000 0 0",
               {upd_ready, rd_start, wr_start, mgu_valid, busy}, active_count, rd_addr);
    else n_pass++;
    @(posedge clk);
    #1 resetn = 1'b1;
    starts = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rd_start === 1'b1 || wr_start === 1'b1 || mgu_valid === 1'b1) starts++;
    end
    n_total++;
    if (starts != 0 || busy !== 1'b0) $display("FAIL rst_mid_quiet: pulses=%0d busy=%b required 0 0", starts, busy);
    else n_pass++;
    obs_rd.delete(); exp_rd.delete(); obs_wr.delete(); exp_wr.delete(); obs_mgu.delete(); exp_mgu.delete();
    exp_cnt = 0;
    mmem = mem;
    wr_lat = 1;
    @(negedge clk);
    push(33'h3020, 32'd1);
    upd_valid = 1'b0;
    drain(1'b0);
    sb_check("after_reset");
  endtask

  initial begin
    upd_data = '0; upd_valid = 1'b0; mode = 2'd0; threshold = '0; mgu_ready = 1'b1;
    test_reset();
    test_min();
    test_no_activate();
    test_add();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
